unsigned_seq_div_restoring: RTL and testbench
=============================================

Name: unsigned_seq_div_restoring

Overview:
- Sequential unsigned restoring divider, the inverse of the team's unsigned sequential right-shift multiplier.
- Takes a 2N-bit dividend (multiplier-product width) and an N-bit divisor, and produces one quotient bit per clock.
- Uses the same clk/rst/load operand interface as the multiplier, so the multiplier benches and divider benches can be chained: multiply, then divide the product back.

Parameters:
- N, 6, divisor width; dividend and quotient are 2N bits, remainder is N bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  start request, level input; a start is taken on its rising edge (sampled high, previous sample low).
- dividend  input  2N  unsigned dividend; captured at start.
- divisor  input  N  unsigned divisor; captured at start.
- quotient  output  2N  registered result quotient.
- remainder  output  N  registered result remainder.
- busy  output  1  high while iterating.
- done  output  1  high from completion until the next start or reset.
- dbz  output  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - rst high at an edge clears: state=IDLE, quotient=0, remainder=0, busy=0, done=0, dbz=0, internal registers=0, load_prev=0.
  - rst has priority over everything and aborts any operation in progress. No partial result is ever written.
- Start detection:
  - start = load & ~load_prev; load_prev is registered every cycle.
  - If load is held high across reset release, a start occurs at the first edge after reset.
  - A start is accepted only in IDLE or DONE. In RUN it is ignored; load_prev still updates, so a level held through RUN does not restart the operation.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start at edge k:
  - Capture the divisor; set the quotient shift register Q = dividend and the partial remainder R (N+1 bits) = 0.
  - Set count = 0, done=0, busy=1, dbz=0, and go to RUN.
  - If the captured divisor is 0, go to DONE instead at edge k+1 with quotient = all ones (2^(2N)-1), remainder=0, dbz=1, done=1, busy=0.
- RUN, one iteration per edge:
  - R = {R[N-1:0], Q[2N-1]}; Q = Q<<1.
  - If R >= {0,divisor}: R = R - divisor and Q[0]=1; otherwise Q[0]=0.
  - count increments each iteration.
  - The iteration at edge k+2N is the last. At that same edge, write quotient = final Q and remainder = final R[N-1:0], set done=1, busy=0, and go to DONE.
- Latency: 2N clocks from the start edge to done high (12 clocks = 120 ns for N=6 at a 10 ns clock).
- Output holding:
  - quotient and remainder hold the previous result through a subsequent RUN.
  - They change only when an operation completes or on reset.
  - done drops at the start edge of the next operation.
- Width rules:
  - All arithmetic is unsigned.
  - The compare/subtract is N+1 bits wide, so R never overflows.
  - The quotient always fits in 2N bits, and the remainder is always < divisor.
- Operand changes: dividend and divisor may change freely after the start edge without affecting the operation in progress.
- Inputs of X or Z are not handled.

Test Plan:
- rst=1 for 10 cycles, then dividend=171, divisor=9, load rising -> busy for 12 cycles, then done=1, quotient=19, remainder=0, dbz=0.
- dividend=100, divisor=7 -> quotient=14, remainder=2. Follow with dividend=4095, divisor=63 -> quotient=65, remainder=0. Follow with dividend=0, divisor=37 -> quotient=0, remainder=0.
- dividend=3213, divisor=1 -> quotient=3213, remainder=0. Follow with dividend=50, divisor=63 -> quotient=0, remainder=50.
- divisor=0, dividend=500 -> one cycle after start: done=1, dbz=1, quotient=4095, remainder=0. A next division of 625/25 clears dbz and gives quotient=25, remainder=0.
- load held high for 30 cycles -> exactly one operation; done stays high with the result stable. A second rising edge of load during RUN is ignored and the result matches the first operands.
- rst asserted at iteration 6 of 171/9 -> next cycle all outputs are 0 and state is IDLE. A fresh start of 171/9 then completes correctly in 12 cycles.

Source files
------------

// File: rtl/unsigned_seq_div_restoring.sv
// Sequential unsigned restoring divider.
// Divides a 2N-bit dividend by an N-bit divisor and produces one quotient bit per clock.
// The clk/rst/load operand interface matches the sequential shift multiplier, so a
// product from the multiplier can be fed straight back in to be divided.
// A divisor of zero finishes one clock after the start with an all-ones quotient and dbz set.

module unsigned_seq_div_restoring #(
    parameter int N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    // The iteration counter must reach 2N-1, which marks the final iteration.
    localparam int            CW   = $clog2(2*N + 1);
    localparam logic [CW-1:0] LAST = CW'(2*N - 1);

    // Controller states.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            loadPrev_q;
    logic [N-1:0]    divisor_q, divisor_d;
    logic [2*N-1:0]  qReg_q, qReg_d;
    // The partial remainder is always below the divisor after each step, so its
    // top bit would always be zero. Only N bits are stored; the extra bit exists
    // only in the shifted value that feeds the compare.
    logic [N-1:0]    rReg_q, rReg_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            start;
    logic [N:0]      rShift;
    logic            fits;
    logic [N-1:0]    rIter;
    logic [2*N-1:0]  qIter;

    // A start is a rising edge on the load level.
    assign start = load & ~loadPrev_q;

    // One restoring step: shift the next dividend bit into the partial remainder,
    // then subtract the divisor when it fits. The compare is N+1 bits wide, so the
    // shifted remainder can never overflow.
    always_comb begin
        rShift = {rReg_q, qReg_q[2*N-1]};
        fits   = (rShift >= {1'b0, divisor_q});
        rIter  = fits ? N'(rShift - {1'b0, divisor_q}) : rShift[N-1:0];
        qIter  = {qReg_q[2*N-2:0], fits};
    end

    // Next-state and datapath control. The result registers are written only when
    // an operation completes, so they keep the previous result during a run.
    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        qReg_d      = qReg_q;
        rReg_d      = rReg_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = done_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    divisor_d = divisor;
                    qReg_d    = dividend;
                    rReg_d    = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    dbz_d     = 1'b0;
                    state_d   = RUN;
                end
            end

            RUN: begin
                if (divisor_q == '0) begin
                    // Division by zero takes a single clock and reports the saturated quotient.
                    quotient_d  = '1;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    qReg_d  = qIter;
                    rReg_d  = rIter;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        quotient_d  = qIter;
                        remainder_d = rIter;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any run without writing a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            loadPrev_q  <= 1'b0;
            divisor_q   <= '0;
            qReg_q      <= '0;
            rReg_q      <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            loadPrev_q  <= load;
            divisor_q   <= divisor_d;
            qReg_q      <= qReg_d;
            rReg_q      <= rReg_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
// Self-checking bench for the sequential restoring divider.
// Expected results come from plain integer division in the bench.

module tb_unsigned_seq_div_restoring;

    localparam int N       = 6;
    localparam int MAX_LAT = 40;

    logic            clk;
    logic            rst;
    logic            load;
    logic [2*N-1:0]  dividend;
    logic [N-1:0]    divisor;
    logic [2*N-1:0]  quotient;
    logic [N-1:0]    remainder;
    logic            busy;
    logic            done;
    logic            dbz;

    int checkCount;
    int passCount;

    logic [2*N-1:0] prevQ;
    logic [N-1:0]   prevR;
    logic           prevDbz;

    unsigned_seq_div_restoring #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: ordinary unsigned division, saturating on a zero divisor.
    function automatic logic [2*N-1:0] refQuot(input logic [2*N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) return {(2*N){1'b1}};
        return (2*N)'(ia / ib);
    endfunction

    function automatic logic [N-1:0] refRem(input logic [2*N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) return '0;
        return N'(ia % ib);
    endfunction

    // Wait for done, counting clocks after the start edge, then check the result.
    task automatic waitAndCheck(input logic [2*N-1:0] a, input logic [N-1:0] b, input string tag);
        int lat;
        logic [2*N-1:0] expQ;
        logic [N-1:0]   expR;
        int expLat;
        lat = 0;
        while (!done && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
            if (!done) checkOutput({tag, ".qHeldRun"}, quotient, prevQ);
        end
        expQ   = refQuot(a, b);
        expR   = refRem(a, b);
        expLat = (b == '0) ? 1 : 2*N;
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".quotient"}, quotient, expQ);
        checkOutput({tag, ".remainder"}, remainder, expR);
        checkOutput({tag, ".dbz"}, dbz, (b == '0));
        checkOutput({tag, ".busyEnd"}, busy, 0);
        prevQ   = expQ;
        prevR   = expR;
        prevDbz = (b == '0);
    endtask

    // Present operands with a load pulse, scramble the operands after the start edge,
    // and check the whole operation.
    task automatic applyStimulus(input logic [2*N-1:0] a, input logic [N-1:0] b, input string tag);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        load     = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".busyStart"}, busy, 1);
        checkOutput({tag, ".doneStart"}, done, 0);
        checkOutput({tag, ".dbzStart"}, dbz, 0);
        checkOutput({tag, ".qHeld"}, quotient, prevQ);
        checkOutput({tag, ".rHeld"}, remainder, prevR);
        load     = 1'b0;
        dividend = (2*N)'($urandom());
        divisor  = N'($urandom());
        waitAndCheck(a, b, tag);
    endtask

    initial begin
        logic [2*N-1:0] ra;
        logic [N-1:0]   rb;

        checkCount = 0;
        passCount  = 0;
        prevQ      = '0;
        prevR      = '0;
        prevDbz    = 1'b0;
        rst        = 1'b1;
        load       = 1'b0;
        dividend   = '0;
        divisor    = '0;

        repeat (10) @(negedge clk);
        checkOutput("reset.quotient", quotient, 0);
        checkOutput("reset.remainder", remainder, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.dbz", dbz, 0);
        rst = 1'b0;

        // Directed cases.
        applyStimulus(12'd171, 6'd9, "d171_9");
        applyStimulus(12'd100, 6'd7, "d100_7");
        applyStimulus(12'd4095, 6'd63, "d4095_63");
        applyStimulus(12'd0, 6'd37, "d0_37");
        applyStimulus(12'd3213, 6'd1, "d3213_1");
        applyStimulus(12'd50, 6'd63, "d50_63");
        applyStimulus(12'd500, 6'd0, "dbz500");
        applyStimulus(12'd625, 6'd25, "d625_25");

        // Load held high: exactly one operation, result stays stable afterwards.
        @(negedge clk);
        dividend = 12'd2000;
        divisor  = 6'd45;
        load     = 1'b1;
        @(negedge clk);
        checkOutput("hold.busyStart", busy, 1);
        waitAndCheck(12'd2000, 6'd45, "hold");
        dividend = 12'd7;
        divisor  = 6'd3;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("hold.doneStable", done, 1);
            checkOutput("hold.busyStable", busy, 0);
            checkOutput("hold.qStable", quotient, prevQ);
            checkOutput("hold.rStable", remainder, prevR);
        end
        load = 1'b0;

        // A second rising edge on load during a run must not restart it.
        @(negedge clk);
        dividend = 12'd100;
        divisor  = 6'd7;
        load     = 1'b1;
        @(negedge clk);
        checkOutput("rerun.busyStart", busy, 1);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dividend = 12'd4095;
        divisor  = 6'd63;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        begin
            int lat;
            lat = 3;
            while (!done && lat < MAX_LAT) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("rerun.latency", lat, 2*N);
            checkOutput("rerun.quotient", quotient, 14);
            checkOutput("rerun.remainder", remainder, 2);
            prevQ = 12'd14;
            prevR = 6'd2;
        end

        // Reset in the middle of a run aborts it and clears every output.
        @(negedge clk);
        dividend = 12'd171;
        divisor  = 6'd9;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort.busyBefore", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.quotient", quotient, 0);
        checkOutput("abort.remainder", remainder, 0);
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.done", done, 0);
        checkOutput("abort.dbz", dbz, 0);
        rst   = 1'b0;
        prevQ = '0;
        prevR = '0;
        repeat (2) @(negedge clk);
        checkOutput("abort.idleDone", done, 0);
        checkOutput("abort.idleBusy", busy, 0);
        applyStimulus(12'd171, 6'd9, "afterAbort");

        // Randomised operands, with an occasional zero divisor.
        for (int i = 0; i < 24; i++) begin
            ra = (2*N)'($urandom());
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
            applyStimulus(ra, rb, "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
